// File: rtl/input_port.sv
// Bus-facing input port: external bytes are buffered in a small FIFO and
// handed to the bus controller one byte per read cycle, with sticky error flags.
module input_port #(
    parameter logic [3:0] SEL_ID = 4'b1010,
    parameter int         DEPTH  = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] SEL,
    input  logic       EN,
    input  logic       OE,
    input  logic [7:0] DIN,
    input  logic       DIN_VALID,
    output logic       DIN_READY,
    output logic [7:0] BUS_OUT,
    output logic       BUS_DRV,
    output logic [4:0] COUNT,
    output logic       OVF,
    output logic       UNF,
    input  logic       CLR
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [4:0]    r_count;
    logic          r_ovf;
    logic          r_unf;

    logic w_rd;
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_ovf_set;
    logic w_unf_set;

    assign w_rd      = (SEL == SEL_ID) & EN & OE;
    assign w_empty   = (r_count == 5'd0);
    assign w_full    = (r_count == 5'(DEPTH));
    assign w_push    = DIN_VALID & ~w_full;
    assign w_pop     = w_rd & ~w_empty;
    assign w_ovf_set = DIN_VALID & w_full;
    assign w_unf_set = w_rd & w_empty;

    // Ready only looks at occupancy, so a full FIFO refuses a byte even when a pop is pending.
    assign DIN_READY = ~w_full;
    assign BUS_DRV   = w_rd & RESET_N;
    assign BUS_OUT   = (w_pop & RESET_N) ? r_mem[r_rptr] : 8'h00;
    assign COUNT     = r_count;
    assign OVF       = r_ovf;
    assign UNF       = r_unf;

    // Storage is never cleared; an empty count keeps stale entries off the bus.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= DIN;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 5'd0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 5'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 5'd1;
            end
            // A new error event wins over a clear arriving in the same cycle.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (CLR) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (CLR) begin
                r_unf <= 1'b0;
            end
        end
    end

endmodule
